bus_snoop_controller: RTL

Sequences one MESI bus transaction after the round-robin arbiter grants an L1. It latches the granted L1's command and address, then broadcasts a snoop to the other L1s and collects their responses, with a timeout. It resolves the data source (cache-to-cache with writeback, or memory), returns data plus a shared flag to the requester, and holds bus_busy until the requester releases its grant.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/snoop_collector.sv | 101 ++++++++++
 rtl/bus_snoop_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types for the MESI bus snoop controller: bus commands, controller states,
// default snoop timeout and a saturating-counter helper.
package bus_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    BUS_RD   = 2'd1,
    BUS_RDX  = 2'd2,
    BUS_UPGR = 2'd3
  } bus_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_COLLECT,
    S_WB,
    S_MEM_RD,
    S_RESP,
    S_DONE
  } snoop_state_e;

  localparam int DEFAULT_SNOOP_TIMEOUT = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/snoop_collector.sv
// Accumulates snoop acks with a timeout and resolves hit/dirty/data for one transaction.
// Acks are taken only while active; clear restarts the accumulation and the timer.
module snoop_collector
  import bus_pkg::*;
#(
  parameter int NUM_L1        = 4,
  parameter int DATA_W        = 32,
  parameter int SNOOP_TIMEOUT = DEFAULT_SNOOP_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     active,
  input  logic [NUM_L1-1:0]        mask,
  input  logic [1:0]               cmd,
  input  logic [NUM_L1-1:0]        snoop_ack,
  input  logic [NUM_L1-1:0]        snoop_hit,
  input  logic [NUM_L1-1:0]        snoop_dirty,
  input  logic [NUM_L1*DATA_W-1:0] snoop_data,
  output logic                     done,
  output logic                     timeout,
  output logic                     shared,
  output logic                     dirty_found,
  output logic [DATA_W-1:0]        data
);

  localparam int TIMER_W = $clog2(SNOOP_TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SNOOP_TIMEOUT - 1);

  logic [NUM_L1-1:0]  ack_seen_q, ack_seen_d;
  logic [NUM_L1-1:0]  hit_q, hit_d;
  logic [NUM_L1-1:0]  dirty_q, dirty_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [DATA_W-1:0]  data_q [NUM_L1];
  logic [DATA_W-1:0]  data_d [NUM_L1];
  logic [DATA_W-1:0]  eff_data [NUM_L1];

  logic [NUM_L1-1:0] new_acks;
  logic [NUM_L1-1:0] hit_all;
  logic [NUM_L1-1:0] dirty_all;
  logic              all_acked;
  logic              expired;

  assign new_acks  = active ? (snoop_ack & mask) : '0;
  assign hit_all   = hit_q | (new_acks & snoop_hit);
  assign dirty_all = dirty_q | (new_acks & snoop_dirty);
  assign all_acked = ((ack_seen_q | new_acks) == mask);
  assign expired   = (timer_q == TIMER_LAST);

  assign done        = active && (all_acked || expired);
  assign timeout     = active && !all_acked && expired;
  assign shared      = (cmd == BUS_RD) && (|hit_all);
  assign dirty_found = |dirty_all;

  always_comb begin
    ack_seen_d = clear ? '0 : (ack_seen_q | new_acks);
    hit_d      = clear ? '0 : hit_all;
    dirty_d    = clear ? '0 : dirty_all;
    timer_d    = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (active && !expired) begin
      timer_d = timer_q + 1'b1;
    end
    for (int i = 0; i < NUM_L1; i++) begin
      eff_data[i] = new_acks[i] ? snoop_data[i*DATA_W +: DATA_W] : data_q[i];
      data_d[i]   = clear ? '0 : eff_data[i];
    end
  end

  // Lowest-index dirty responder supplies the line
  always_comb begin
    data = '0;
    for (int i = NUM_L1 - 1; i >= 0; i--) begin
      if (dirty_all[i]) begin
        data = eff_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_seen_q <= '0;
      hit_q      <= '0;
      dirty_q    <= '0;
      timer_q    <= '0;
      for (int i = 0; i < NUM_L1; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      ack_seen_q <= ack_seen_d;
      hit_q      <= hit_d;
      dirty_q    <= dirty_d;
      timer_q    <= timer_d;
      for (int i = 0; i < NUM_L1; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: rtl/bus_snoop_controller.sv
// Sequences one MESI bus transaction: latch, snoop, collect, writeback/memory read, respond.
// Optional SNOOP_STATS_EN adds saturating transaction, cache-to-cache and timeout counters.
module bus_snoop_controller
  import bus_pkg::*;
#(
  parameter int NUM_L1        = 4,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int SNOOP_TIMEOUT = DEFAULT_SNOOP_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_L1-1:0]        bus_grant,
  input  logic [NUM_L1*2-1:0]      req_cmd,
  input  logic [NUM_L1*ADDR_W-1:0] req_addr,
  output logic                     snoop_valid,
  output logic [1:0]               snoop_cmd,
  output logic [ADDR_W-1:0]        snoop_addr,
  output logic [NUM_L1-1:0]        snoop_mask,
  input  logic [NUM_L1-1:0]        snoop_ack,
  input  logic [NUM_L1-1:0]        snoop_hit,
  input  logic [NUM_L1-1:0]        snoop_dirty,
  input  logic [NUM_L1*DATA_W-1:0] snoop_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [NUM_L1-1:0]        resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_shared,
  output logic                     bus_busy,
`ifdef SNOOP_STATS_EN
  output logic                     timeout_err,
  output logic [15:0]              stat_txn,
  output logic [15:0]              stat_c2c,
  output logic [15:0]              stat_timeout
`else
  output logic                     timeout_err
`endif
);

  localparam int OWN_W = (NUM_L1 > 1) ? $clog2(NUM_L1) : 1;

  snoop_state_e      state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  bus_cmd_e          cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              shared_q, shared_d;

  logic [OWN_W-1:0]  grant_idx;
  logic [1:0]        cmd_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic              start;
  logic [NUM_L1-1:0] owner_onehot;

  logic              col_done;
  logic              col_timeout;
  logic              col_shared;
  logic              col_dirty;
  logic [DATA_W-1:0] col_data;

  // Lowest granted index wins if the arbiter ever presents more than one bit
  always_comb begin
    grant_idx = '0;
    cmd_sel   = '0;
    addr_sel  = '0;
    for (int i = NUM_L1 - 1; i >= 0; i--) begin
      if (bus_grant[i]) begin
        grant_idx = OWN_W'(i);
        cmd_sel   = req_cmd[i*2 +: 2];
        addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign start        = (|bus_grant) && (cmd_sel != NONE);
  assign owner_onehot = NUM_L1'(1) << owner_q;

  snoop_collector #(
    .NUM_L1        (NUM_L1),
    .DATA_W        (DATA_W),
    .SNOOP_TIMEOUT (SNOOP_TIMEOUT)
  ) u_collector (
    .clk         (clk),
    .reset       (reset),
    .clear       (state_q == S_SNOOP),
    .active      (state_q == S_COLLECT),
    .mask        (~owner_onehot),
    .cmd         (cmd_q),
    .snoop_ack   (snoop_ack),
    .snoop_hit   (snoop_hit),
    .snoop_dirty (snoop_dirty),
    .snoop_data  (snoop_data),
    .done        (col_done),
    .timeout     (col_timeout),
    .shared      (col_shared),
    .dirty_found (col_dirty),
    .data        (col_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_SNOOP;
      S_SNOOP:   state_d = S_COLLECT;
      S_COLLECT: begin
        if (col_done) begin
          if (cmd_q == BUS_UPGR) state_d = S_RESP;
          else if (col_dirty)    state_d = S_WB;
          else                   state_d = S_MEM_RD;
        end
      end
      S_WB:      if (mem_ack) state_d = S_RESP;
      S_MEM_RD:  if (mem_ack) state_d = S_RESP;
      S_RESP:    state_d = S_DONE;
      S_DONE:    if (!bus_grant[owner_q]) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    shared_d = shared_q;
    if (state_q == S_IDLE && start) begin
      owner_d  = grant_idx;
      cmd_d    = bus_cmd_e'(cmd_sel);
      addr_d   = addr_sel;
      data_d   = '0;
      shared_d = 1'b0;
    end else if (state_q == S_COLLECT && col_done) begin
      shared_d = col_shared;
      data_d   = (cmd_q != BUS_UPGR && col_dirty) ? col_data : '0;
    end else if (state_q == S_MEM_RD && mem_ack) begin
      data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= '0;
      cmd_q    <= NONE;
      addr_q   <= '0;
      data_q   <= '0;
      shared_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      shared_q <= shared_d;
    end
  end

  always_comb begin
    snoop_valid = 1'b0;
    snoop_cmd   = cmd_q;
    snoop_addr  = addr_q;
    snoop_mask  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    resp_valid  = '0;
    resp_data   = '0;
    resp_shared = 1'b0;
    bus_busy    = (state_q != S_IDLE);
    case (state_q)
      S_SNOOP: begin
        snoop_valid = 1'b1;
        snoop_mask  = ~owner_onehot;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
      end
      S_RESP: begin
        resp_valid  = owner_onehot;
        resp_data   = data_q;
        resp_shared = shared_q;
      end
      default: ;
    endcase
  end

  assign timeout_err = col_timeout;

`ifdef SNOOP_STATS_EN
  logic [15:0] stat_txn_q, stat_txn_d;
  logic [15:0] stat_c2c_q, stat_c2c_d;
  logic [15:0] stat_timeout_q, stat_timeout_d;

  always_comb begin
    stat_txn_d     = stat_txn_q;
    stat_c2c_d     = stat_c2c_q;
    stat_timeout_d = stat_timeout_q;
    if (state_d == S_RESP && state_q != S_RESP) stat_txn_d = sat_inc16(stat_txn_q);
    if (state_d == S_WB && state_q != S_WB)     stat_c2c_d = sat_inc16(stat_c2c_q);
    if (col_timeout)                            stat_timeout_d = sat_inc16(stat_timeout_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_txn_q     <= '0;
      stat_c2c_q     <= '0;
      stat_timeout_q <= '0;
    end else begin
      stat_txn_q     <= stat_txn_d;
      stat_c2c_q     <= stat_c2c_d;
      stat_timeout_q <= stat_timeout_d;
    end
  end

  assign stat_txn     = stat_txn_q;
  assign stat_c2c     = stat_c2c_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule
